// File: rtl/pq_seq_pkg.sv
// Shared types for the priority-queue command sequencer: opcodes, response status, FSM states.
package pq_seq_pkg;

  typedef enum logic [1:0] {
    OP_PEEK = 2'd0,
    OP_ENQ  = 2'd1,
    OP_DEQ  = 2'd2,
    OP_REP  = 2'd3
  } pq_op_e;

  typedef enum logic [1:0] {
    ST_OK        = 2'd0,
    ST_ERR_FULL  = 2'd1,
    ST_ERR_EMPTY = 2'd2
  } pq_status_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2,
    S_RESP  = 2'd3
  } seq_state_e;

  localparam int unsigned PQ_GAP_W = 8;

  function automatic logic op_needs_entry(pq_op_e op);
    return (op == OP_DEQ) || (op == OP_REP);
  endfunction

endpackage

// File: rtl/pq_cmd_fifo.sv
// Command FIFO: head is visible in the same cycle, push and pop may coincide.
// rdy_o is a registered not-full flag (low while in reset), so it has no input-to-output path.
module pq_cmd_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             empty_o,
  output logic             rdy_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             rdy_q;
  logic             do_push, do_pop;

  assign do_push = push_i && rdy_q;
  assign do_pop  = pop_i && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d != CNT_MAX);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_q];
  assign empty_o    = (cnt_q == '0);
  assign rdy_o      = rdy_q;

endmodule

// File: rtl/pq_op_sequencer.sv
// Front-end for the systolic max-queue: one command at a time, 1-cycle issue pulse, fixed idle gap.
// Response after edge T2+GAP (T2 for PEEK/rejects); holds the response until i_rsp_ready, FIFO absorbs input.
module pq_op_sequencer
  import pq_seq_pkg::*;
#(
  parameter int unsigned QUEUE_SIZE = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ENQ_GAP    = 2,
  parameter int unsigned DEQ_GAP    = 3,
  parameter int unsigned REP_GAP    = 2
) (
  input  logic                            i_CLK,
  input  logic                            i_RSTn,
  input  logic                            i_cmd_valid,
  output logic                            o_cmd_ready,
  input  logic [1:0]                      i_cmd_op,
  input  logic [DATA_WIDTH-1:0]           i_cmd_data,
  output logic                            o_rsp_valid,
  input  logic                            i_rsp_ready,
  output logic [DATA_WIDTH-1:0]           o_rsp_data,
  output logic [1:0]                      o_rsp_status,
  output logic                            o_pq_wrt,
  output logic                            o_pq_read,
  output logic [DATA_WIDTH-1:0]           o_pq_data,
  input  logic                            i_pq_full,
  input  logic                            i_pq_empty,
  input  logic [DATA_WIDTH-1:0]           i_pq_data,
  output logic [$clog2(QUEUE_SIZE+1)-1:0] o_count,
  output logic                            o_mismatch
);
  localparam int unsigned   CW       = $clog2(QUEUE_SIZE+1);
  localparam int unsigned   GW       = PQ_GAP_W;
  localparam logic [CW-1:0] CNT_FULL = CW'(QUEUE_SIZE);

  typedef struct packed {
    pq_op_e                op;
    logic [DATA_WIDTH-1:0] data;
  } cmd_t;

  cmd_t push_cmd, head_cmd;
  logic fifo_empty, fifo_pop;

  assign push_cmd = '{op: pq_op_e'(i_cmd_op), data: i_cmd_data};

  pq_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk_i      (i_CLK),
    .rst_ni     (i_RSTn),
    .push_i     (i_cmd_valid),
    .push_dat_i (push_cmd),
    .pop_i      (fifo_pop),
    .head_dat_o (head_cmd),
    .empty_o    (fifo_empty),
    .rdy_o      (o_cmd_ready)
  );

  seq_state_e            state_q, state_d;
  pq_op_e                op_q, op_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  wrt_q, wrt_d, rd_q, rd_d;
  logic [DATA_WIDTH-1:0] pqd_q, pqd_d;
  logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  pq_status_e            rsp_sts_q, rsp_sts_d;
  logic                  mis_q, mis_d;
  logic                  cnt_is_full, cnt_is_empty;

  assign cnt_is_full  = (cnt_q == CNT_FULL);
  assign cnt_is_empty = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    wrt_d     = 1'b0;
    rd_d      = 1'b0;
    pqd_d     = '0;
    rsp_dat_d = rsp_dat_q;
    rsp_sts_d = rsp_sts_q;
    mis_d     = mis_q;
    fifo_pop  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if ((cnt_is_full != i_pq_full) || (cnt_is_empty != i_pq_empty)) mis_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          op_d      = head_cmd.op;
          state_d   = S_ISSUE;
          rsp_dat_d = '0;
          rsp_sts_d = ST_OK;
          if (head_cmd.op == OP_ENQ && cnt_is_full) begin
            rsp_sts_d = ST_ERR_FULL;
          end else if (op_needs_entry(head_cmd.op) && cnt_is_empty) begin
            rsp_sts_d = ST_ERR_EMPTY;
          end else begin
            case (head_cmd.op)
              OP_ENQ: begin
                wrt_d = 1'b1;
                pqd_d = head_cmd.data;
              end
              OP_DEQ: rd_d = 1'b1;
              OP_REP: begin
                wrt_d = 1'b1;
                rd_d  = 1'b1;
                pqd_d = head_cmd.data;
              end
              default: rsp_dat_d = cnt_is_empty ? '0 : i_pq_data;
            endcase
          end
        end
      end

      // PEEK and rejected commands spend this slot with no pulse, then respond.
      S_ISSUE: begin
        if (wrt_q || rd_q) begin
          state_d = S_GAP;
          case (op_q)
            OP_ENQ: begin
              cnt_d = cnt_q + CW'(1);
              gap_d = GW'(ENQ_GAP);
            end
            OP_DEQ: begin
              cnt_d     = cnt_q - CW'(1);
              gap_d     = GW'(DEQ_GAP);
              rsp_dat_d = i_pq_data;
            end
            default: begin
              gap_d     = GW'(REP_GAP);
              rsp_dat_d = i_pq_data;
            end
          endcase
        end else begin
          state_d = S_RESP;
        end
      end

      S_GAP: begin
        if (gap_q <= GW'(1)) state_d = S_RESP;
        else                 gap_d   = gap_q - GW'(1);
      end

      default: begin
        if (i_rsp_ready) begin
          state_d   = S_IDLE;
          rsp_dat_d = '0;
          rsp_sts_d = ST_OK;
        end
      end
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q   <= S_IDLE;
      op_q      <= OP_PEEK;
      cnt_q     <= '0;
      gap_q     <= '0;
      wrt_q     <= 1'b0;
      rd_q      <= 1'b0;
      pqd_q     <= '0;
      rsp_dat_q <= '0;
      rsp_sts_q <= ST_OK;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      wrt_q     <= wrt_d;
      rd_q      <= rd_d;
      pqd_q     <= pqd_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_sts_q <= rsp_sts_d;
      mis_q     <= mis_d;
    end
  end

  assign o_rsp_valid  = (state_q == S_RESP);
  assign o_rsp_data   = rsp_dat_q;
  assign o_rsp_status = rsp_sts_q;
  assign o_pq_wrt     = wrt_q;
  assign o_pq_read    = rd_q;
  assign o_pq_data    = pqd_q;
  assign o_count      = cnt_q;
  assign o_mismatch   = mis_q;

endmodule

// File: tb/tb_pq_op_sequencer.sv
// Directed bench for pq_op_sequencer with a behavioural max-first queue model on the o_pq_* side.
module tb_pq_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        pq_wrt, pq_read;
  logic [15:0] pq_data;
  logic        pq_full, pq_empty;
  logic [15:0] pq_top;
  logic [3:0]  count;
  logic        mismatch;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pq_op_sequencer dut (
    .i_CLK        (clk),
    .i_RSTn       (rst_n),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_op     (cmd_op),
    .i_cmd_data   (cmd_data),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_data   (rsp_data),
    .o_rsp_status (rsp_status),
    .o_pq_wrt     (pq_wrt),
    .o_pq_read    (pq_read),
    .o_pq_data    (pq_data),
    .i_pq_full    (pq_full),
    .i_pq_empty   (pq_empty),
    .i_pq_data    (pq_top),
    .o_count      (count),
    .o_mismatch   (mismatch)
  );

  // Behavioural queue, kept sorted descending; not reset with the sequencer.
  logic [15:0] mq [8];
  int          mn = 0;
  logic [15:0] mt [9];
  int          mt_n, mp;

  assign pq_full  = (mn == 8);
  assign pq_empty = (mn == 0);
  assign pq_top   = (mn == 0) ? 16'd0 : mq[0];

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) mt[i] = mq[i];
    mt[8] = 16'd0;
    mt_n  = mn;
    if (pq_read && mt_n > 0) begin
      for (int i = 0; i < 8; i++) mt[i] = mt[i+1];
      mt_n--;
    end
    if (pq_wrt && mt_n < 8) begin
      mp = mt_n;
      while (mp > 0 && mt[mp-1] < pq_data) begin
        mt[mp] = mt[mp-1];
        mp--;
      end
      mt[mp] = pq_data;
      mt_n++;
    end
    for (int i = 0; i < 8; i++) mq[i] <= mt[i];
    mn <= mt_n;
  end

  // Pulse monitor on the queue-side outputs.
  int          cyc = 0, last_pulse = -1, min_gap = 1000;
  int          wrt_n = 0, rd_n = 0, both_n = 0, multi = 0, dat_leak = 0;
  logic        pulse_prev = 1'b0;
  logic [15:0] wq [$];

  always @(negedge clk) begin
    cyc++;
    if (pq_wrt || pq_read) begin
      if (pulse_prev) multi++;
      if (last_pulse >= 0 && (cyc - last_pulse - 1) < min_gap) min_gap = cyc - last_pulse - 1;
      last_pulse = cyc;
      if (pq_wrt) begin
        wrt_n++;
        wq.push_back(pq_data);
      end
      if (pq_read) rd_n++;
      if (pq_wrt && pq_read) both_n++;
    end
    if (!pq_wrt && pq_data != 16'd0) dat_leak++;
    pulse_prev = pq_wrt || pq_read;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input logic [1:0] op, input logic [15:0] d);
    int n = 0;
    cmd_op    = op;
    cmd_data  = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [15:0] d, output logic [1:0] s, output int lat);
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
    d = rsp_data;
    s = rsp_status;
    @(negedge clk);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [15:0] d, input logic [15:0] ed,
                        input logic [1:0] es, input int el, input string tag);
    logic [15:0] rd;
    logic [1:0]  rs;
    int          lat;
    send(op, d);
    get_rsp(rd, rs, lat);
    chk({tag, "_data"}, rd, ed);
    chk({tag, "_status"}, rs, es);
    chk({tag, "_lat"}, lat, el);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [15:0] d0, rd;
    logic [1:0]  rs;
    int          lat, p0, b0, n;
    logic        stable, seen;
    logic [15:0] fill_v [8];
    logic [15:0] bp_exp [5];

    fill_v = '{16'd900, 16'd200, 16'd300, 16'd400, 16'd50, 16'd60, 16'd70, 16'd80};
    bp_exp = '{16'd1000, 16'd400, 16'd300, 16'd0, 16'd300};

    rst_n = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 16'd0; rsp_ready = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_pq_wrt", pq_wrt, 0);
    chk("rst_count", count, 0);
    chk("rst_mismatch", mismatch, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("cmd_ready_after_rst", cmd_ready, 1);

    do_cmd(2'd1, 16'd100, 16'd0, 2'd0, 4, "enq100");
    do_cmd(2'd1, 16'd500, 16'd0, 2'd0, 4, "enq500");
    do_cmd(2'd1, 16'd7,   16'd0, 2'd0, 4, "enq7");
    chk("enq_count", count, 3);
    chk("enq_pulses", wrt_n, 3);
    chk("enq_pdata0", wq[0], 100);
    chk("enq_pdata1", wq[1], 500);
    chk("enq_pdata2", wq[2], 7);

    p0 = rd_n;
    do_cmd(2'd2, 16'd0, 16'd500, 2'd0, 5, "deq1");
    do_cmd(2'd2, 16'd0, 16'd100, 2'd0, 5, "deq2");
    do_cmd(2'd2, 16'd0, 16'd7,   2'd0, 5, "deq3");
    chk("deq_count", count, 0);
    chk("deq_pulses", rd_n - p0, 3);

    p0 = wrt_n + rd_n;
    do_cmd(2'd2, 16'd0, 16'd0, 2'd2, 2, "deq_empty");
    do_cmd(2'd3, 16'd9, 16'd0, 2'd2, 2, "rep_empty");
    do_cmd(2'd0, 16'd0, 16'd0, 2'd0, 2, "peek_empty");
    chk("reject_pulses", wrt_n + rd_n - p0, 0);

    for (int i = 0; i < 8; i++) do_cmd(2'd1, fill_v[i], 16'd0, 2'd0, 4, "fill");
    chk("fill_count", count, 8);
    p0 = wrt_n + rd_n;
    do_cmd(2'd1, 16'd1, 16'd0, 2'd1, 2, "enq_full");
    chk("enq_full_pulses", wrt_n + rd_n - p0, 0);
    do_cmd(2'd0, 16'd0, 16'd900, 2'd0, 2, "peek900");
    b0 = both_n;
    do_cmd(2'd3, 16'd1000, 16'd900, 2'd0, 4, "rep1000");
    chk("rep_both_pulse", both_n - b0, 1);
    chk("rep_count", count, 8);
    do_cmd(2'd0, 16'd0, 16'd1000, 2'd0, 2, "peek1000");

    rsp_ready = 1'b0;
    send(2'd2, 16'd0);
    send(2'd2, 16'd0);
    send(2'd0, 16'd0);
    send(2'd1, 16'd5);
    send(2'd2, 16'd0);
    chk("bp_cmd_ready_low", cmd_ready, 0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    d0 = rsp_data;
    p0 = wrt_n + rd_n;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== d0 || cmd_ready) stable = 1'b0;
    end
    chk("bp_hold_stable", stable, 1);
    chk("bp_first_data", d0, 1000);
    chk("bp_no_pq_activity", wrt_n + rd_n - p0, 0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      get_rsp(rd, rs, lat);
      chk("bp_rsp_data", rd, bp_exp[i]);
      chk("bp_rsp_status", rs, 0);
    end
    chk("bp_count", count, 6);
    chk("mismatch_clear", mismatch, 0);
    chk("pulse_single_cycle", multi, 0);
    chk("pdata_zero_when_idle", dat_leak, 0);
    chk("min_idle_gap_ge3", (min_gap >= 3), 1);

    p0 = wrt_n + rd_n;
    send(2'd2, 16'd0);
    n = 0;
    while (!pq_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("gap_rst_rsp_valid", rsp_valid, 0);
    chk("gap_rst_count", count, 0);
    chk("gap_rst_pq_read", pq_read, 0);
    chk("gap_rst_cmd_ready", cmd_ready, 0);
    chk("gap_rst_rsp_data", rsp_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("no_rsp_after_rst", seen, 0);
    chk("post_rst_count", count, 0);
    chk("post_rst_pulses", wrt_n + rd_n - p0, 1);
    chk("mismatch_set", mismatch, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
